// File: rtl/sd_server_pkg.sv
// sd_server_pkg: shared state encoding and sector geometry
// for the sd_rd/sd_wr sector responder.
package sd_server_pkg;

  localparam int SECTOR_BYTES = 512;
  localparam int SECTOR_WORDS = 256;

  typedef enum logic [3:0] {
    IDLE,
    CHECK,
    RD_FETCH,
    RD_LO,
    RD_GAP,
    RD_HI,
    RD_GAP2,
    WR_ADDR,
    WR_WAIT,
    WR_LO,
    WR_WAIT2,
    WR_HI,
    WR_MEM,
    HOLD,
    RELEASE
  } srv_state_t;

endpackage

// File: rtl/sd_sector_server.sv
// sd_sector_server: serves 512-byte disk-image sectors from a
// 16-bit memory port to an sd_rd/sd_wr byte-buffer requester.
// Ports: clk_sys, reset (sync, active-high); img_mounted,
//   img_size, sd_lba, sd_rd, sd_wr -> sd_ack, sd_buff_addr,
//   sd_buff_dout, sd_buff_wr; sd_buff_din (1-cycle RAM);
//   mem_addr/mem_dout/mem_rd/mem_we -> mem_din/mem_ack.
// Option SD_SERVER_WP_EN: adds img_wp; protected writes run
//   the byte protocol but never raise mem_we.
module sd_sector_server
  import sd_server_pkg::*;
#(
  parameter logic [24:0] IMG_BASE       = 25'h000000,
  parameter int unsigned ACK_MIN_CYCLES = 16
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        img_mounted,
  input  logic [31:0] img_size,
`ifdef SD_SERVER_WP_EN
  input  logic        img_wp,
`endif
  input  logic [31:0] sd_lba,
  input  logic        sd_rd,
  input  logic        sd_wr,
  output logic        sd_ack,
  output logic [8:0]  sd_buff_addr,
  output logic [7:0]  sd_buff_dout,
  output logic        sd_buff_wr,
  input  logic [7:0]  sd_buff_din,
  output logic [24:0] mem_addr,
  output logic [15:0] mem_dout,
  input  logic [15:0] mem_din,
  output logic        mem_rd,
  output logic        mem_we,
  input  logic        mem_ack
);

  srv_state_t  state_q, state_n;
  logic [31:0] lba_q, lba_n;
  logic        rd_q, rd_n;
  logic        valid_q, valid_n;
  logic [7:0]  w_q, w_n;
  logic [15:0] word_q, word_n;
  logic [15:0] hcnt_q, hcnt_n;
  logic        ack_q, ack_n;
  logic [8:0]  baddr_q, baddr_n;
  logic [7:0]  bdout_q, bdout_n;
  logic        bwr_q, bwr_n;

  logic        last_w;
  logic        fetch_ok;
  logic [15:0] fetch_word;
  logic        hold_done;
  logic        range_ok;
  logic [24:0] sum_addr;
  logic        unused_size;

  // Sector count only uses the upper bits of the byte size.
  assign unused_size = ^img_size[8:0];

  assign last_w     = (w_q == 8'(SECTOR_WORDS - 1));
  assign range_ok   = lba_q < {9'b0, img_size[31:9]};
  // Invalid sectors complete at once with a zero word.
  assign fetch_ok   = !valid_q || mem_ack;
  assign fetch_word = valid_q ? mem_din : 16'h0000;
  assign hold_done  =
    ({16'b0, hcnt_q} + 32'd1) >= ACK_MIN_CYCLES;

  // lba wraps above 2^16 because only 25 address bits exist.
  assign sum_addr = IMG_BASE
                  + {lba_q[15:0], 9'b0}
                  + {16'b0, w_q, 1'b0};

  assign mem_rd   = (state_q == RD_FETCH) && valid_q;
  assign mem_we   = (state_q == WR_MEM) && valid_q;
  assign mem_addr = (mem_rd || mem_we)
                  ? {sum_addr[24:1], 1'b0} : 25'b0;
  assign mem_dout = mem_we ? word_q : 16'h0000;

  assign sd_ack       = ack_q;
  assign sd_buff_addr = baddr_q;
  assign sd_buff_dout = bdout_q;
  assign sd_buff_wr   = bwr_q;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
      lba_q   <= '0;
      rd_q    <= 1'b0;
      valid_q <= 1'b0;
      w_q     <= '0;
      word_q  <= '0;
      hcnt_q  <= '0;
      ack_q   <= 1'b0;
      baddr_q <= '0;
      bdout_q <= '0;
      bwr_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      lba_q   <= lba_n;
      rd_q    <= rd_n;
      valid_q <= valid_n;
      w_q     <= w_n;
      word_q  <= word_n;
      hcnt_q  <= hcnt_n;
      ack_q   <= ack_n;
      baddr_q <= baddr_n;
      bdout_q <= bdout_n;
      bwr_q   <= bwr_n;
    end
  end

  always_comb begin
    state_n = state_q;
    lba_n   = lba_q;
    rd_n    = rd_q;
    valid_n = valid_q;
    w_n     = w_q;
    word_n  = word_q;
    hcnt_n  = hcnt_q;
    ack_n   = ack_q;
    baddr_n = baddr_q;
    bdout_n = bdout_q;
    // Strobe is a single cycle; gap states keep it low.
    bwr_n   = 1'b0;

    if (ack_q && hcnt_q != 16'hFFFF)
      hcnt_n = hcnt_q + 16'd1;

    unique case (state_q)
      IDLE: begin
        if (sd_rd || sd_wr) begin
          lba_n   = sd_lba;
          rd_n    = sd_rd;
          state_n = CHECK;
        end
      end
      CHECK: begin
        ack_n   = 1'b1;
        baddr_n = '0;
        w_n     = '0;
        hcnt_n  = '0;
        valid_n = img_mounted && range_ok;
`ifdef SD_SERVER_WP_EN
        if (!rd_q && img_wp)
          valid_n = 1'b0;
`endif
        state_n = rd_q ? RD_FETCH : WR_ADDR;
      end
      RD_FETCH: begin
        if (fetch_ok) begin
          word_n  = fetch_word;
          bdout_n = fetch_word[7:0];
          baddr_n = {w_q, 1'b0};
          bwr_n   = 1'b1;
          state_n = RD_LO;
        end
      end
      RD_LO: state_n = RD_GAP;
      RD_GAP: begin
        bdout_n = word_q[15:8];
        baddr_n = {w_q, 1'b1};
        bwr_n   = 1'b1;
        state_n = RD_HI;
      end
      RD_HI: state_n = RD_GAP2;
      RD_GAP2: begin
        if (last_w) begin
          state_n = HOLD;
        end else begin
          w_n     = w_q + 8'd1;
          state_n = RD_FETCH;
        end
      end
      WR_ADDR: state_n = WR_WAIT;
      WR_WAIT: begin
        baddr_n = {w_q, 1'b1};
        state_n = WR_LO;
      end
      // din still reflects the even address here.
      WR_LO: begin
        word_n[7:0] = sd_buff_din;
        state_n     = WR_WAIT2;
      end
      WR_WAIT2: state_n = WR_HI;
      WR_HI: begin
        word_n[15:8] = sd_buff_din;
        state_n      = WR_MEM;
      end
      WR_MEM: begin
        if (fetch_ok) begin
          if (last_w) begin
            state_n = HOLD;
          end else begin
            w_n     = w_q + 8'd1;
            baddr_n = {w_q + 8'd1, 1'b0};
            state_n = WR_ADDR;
          end
        end
      end
      HOLD: begin
        if (hold_done) begin
          ack_n   = 1'b0;
          state_n = RELEASE;
        end
      end
      RELEASE: begin
        if (!sd_rd && !sd_wr)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sd_sector_server.sv
// tb_sd_sector_server: randomized scoreboard bench for the
// sector responder, with a behavioural memory/sector model.
module tb_sd_sector_server;

  localparam logic [24:0] IMG_BASE = 25'h1FF0000;
  localparam int ACK_MIN = 1500;

  logic        clk_sys = 1'b0;
  logic        reset;
  logic        img_mounted;
  logic [31:0] img_size;
`ifdef SD_SERVER_WP_EN
  logic        img_wp;
`endif
  logic [31:0] sd_lba;
  logic        sd_rd, sd_wr;
  logic        sd_ack;
  logic [8:0]  sd_buff_addr;
  logic [7:0]  sd_buff_dout;
  logic        sd_buff_wr;
  logic [7:0]  sd_buff_din;
  logic [24:0] mem_addr;
  logic [15:0] mem_dout, mem_din;
  logic        mem_rd, mem_we, mem_ack;

  int tests = 0;
  int fails = 0;
  int rd_acks = 0;
  int we_acks = 0;

  logic [7:0]  ram [512];
  logic [15:0] ref_mem  [logic [23:0]];
  logic [15:0] phys_mem [logic [23:0]];
  logic [16:0] exp_bytes [$];
  logic [40:0] exp_mw [$];

  always #5 clk_sys = ~clk_sys;

  sd_sector_server #(
    .IMG_BASE(IMG_BASE),
    .ACK_MIN_CYCLES(ACK_MIN)
  ) dut (
    .clk_sys(clk_sys),
    .reset(reset),
    .img_mounted(img_mounted),
    .img_size(img_size),
`ifdef SD_SERVER_WP_EN
    .img_wp(img_wp),
`endif
    .sd_lba(sd_lba),
    .sd_rd(sd_rd),
    .sd_wr(sd_wr),
    .sd_ack(sd_ack),
    .sd_buff_addr(sd_buff_addr),
    .sd_buff_dout(sd_buff_dout),
    .sd_buff_wr(sd_buff_wr),
    .sd_buff_din(sd_buff_din),
    .mem_addr(mem_addr),
    .mem_dout(mem_dout),
    .mem_din(mem_din),
    .mem_rd(mem_rd),
    .mem_we(mem_we),
    .mem_ack(mem_ack)
  );

  // Requester buffer RAM with one cycle of read latency.
  always @(posedge clk_sys)
    sd_buff_din <= ram[sd_buff_addr];

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] init_word(input logic [23:0] wa);
    logic [31:0] p;
    p = {8'b0, wa} * 32'd40503;
    return p[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_rd(input logic [23:0] wa);
    if (ref_mem.exists(wa)) return ref_mem[wa];
    return init_word(wa);
  endfunction

  function automatic logic [15:0] phys_rd(input logic [23:0] wa);
    if (phys_mem.exists(wa)) return phys_mem[wa];
    return init_word(wa);
  endfunction

  // Byte address of byte i of a sector, modulo the 25-bit space.
  function automatic logic [24:0] byte_addr(input logic [31:0] lba,
                                            input int i);
    longint unsigned s;
    s = longint'(IMG_BASE) + longint'(lba) * 512 + longint'(i);
    return 25'(s % 64'h200_0000);
  endfunction

  // Memory responder: random latency, one-cycle ack.
  initial begin
    int dly;
    mem_ack = 1'b0;
    mem_din = 16'h0000;
    dly = 0;
    forever begin
      @(posedge clk_sys); #1;
      if (mem_ack || reset) begin
        mem_ack = 1'b0;
      end else if (mem_rd || mem_we) begin
        if (dly == 0) begin
          mem_ack = 1'b1;
          if (mem_rd) mem_din = phys_rd(mem_addr[24:1]);
          else phys_mem[mem_addr[24:1]] = mem_dout;
          dly = $urandom_range(0, 3);
        end else begin
          dly--;
        end
      end
    end
  end

  // Monitor: pops expectations whenever the DUT presents output.
  initial begin
    logic prev_wr;
    logic [16:0] eb;
    logic [40:0] em;
    prev_wr = 1'b0;
    forever begin
      @(negedge clk_sys);
      if (sd_buff_wr) begin
        chk("strobe_gap", prev_wr, 1'b0);
        if (exp_bytes.size() == 0) begin
          tests++; fails++;
          $display("FAIL rd_byte: got addr %0h expected none",
                   sd_buff_addr);
        end else begin
          eb = exp_bytes.pop_front();
          chk("rd_byte_addr", sd_buff_addr, eb[16:8]);
          chk("rd_byte_data", sd_buff_dout, eb[7:0]);
        end
      end
      prev_wr = sd_buff_wr;
      if (mem_rd && mem_ack) rd_acks++;
      if (mem_we && mem_ack) begin
        we_acks++;
        if (exp_mw.size() == 0) begin
          tests++; fails++;
          $display("FAIL mem_we: got addr %0h expected none",
                   mem_addr);
        end else begin
          em = exp_mw.pop_front();
          chk("mw_addr", mem_addr, em[40:16]);
          chk("mw_data", mem_dout, em[15:0]);
        end
      end
    end
  end

  task automatic do_req(input bit rd, input bit wr,
                        input logic [31:0] lba, input bit mnt,
                        input logic [31:0] size, input bit wp,
                        input int extra);
    bit is_rd, v, up, reack, mem_used;
    int acks, rd0, we0, exp_len;
    logic [24:0] ba;
    logic [15:0] wd;
    is_rd = rd;
    v = mnt && (lba < (size >> 9));
    mem_used = is_rd ? v : (v && !wp);
    if (is_rd) begin
      for (int i = 0; i < 512; i++) begin
        ba = byte_addr(lba, i);
        wd = v ? ref_rd(ba[24:1]) : 16'h0000;
        exp_bytes.push_back({9'(i), ba[0] ? wd[15:8] : wd[7:0]});
      end
    end else if (mem_used) begin
      for (int j = 0; j < 256; j++) begin
        ba = byte_addr(lba, 2 * j);
        wd = {ram[2 * j + 1], ram[2 * j]};
        exp_mw.push_back({ba, wd});
        ref_mem[ba[24:1]] = wd;
      end
    end
    // Without memory stalls each word takes 5 (read) or 6 (write)
    // cycles; HOLD adds one more before the minimum applies.
    exp_len = 0;
    if (!mem_used) begin
      exp_len = (is_rd ? 256 * 5 : 256 * 6) + 1;
      if (exp_len < ACK_MIN) exp_len = ACK_MIN;
    end
    rd0 = rd_acks;
    we0 = we_acks;
    img_mounted = mnt;
    img_size = size;
    sd_lba = lba;
    sd_rd = rd;
    sd_wr = wr;
`ifdef SD_SERVER_WP_EN
    img_wp = wp;
`endif
    up = 1'b0;
    for (int c = 0; c < 8 && !up; c++) begin
      @(posedge clk_sys); #1;
      up = sd_ack;
    end
    chk("ack_rise", up, 1'b1);
    if (!up) begin
      sd_rd = 1'b0; sd_wr = 1'b0;
      exp_bytes.delete(); exp_mw.delete();
      return;
    end
    // Inputs sampled at accept must not matter afterwards.
    sd_lba = $urandom;
    img_mounted = 1'($urandom_range(0, 1));
    acks = 1;
    while (acks < 20000) begin
      @(posedge clk_sys); #1;
      if (!sd_ack) break;
      acks++;
    end
    chk("ack_min", acks >= ACK_MIN, 1'b1);
    if (exp_len != 0) chk("ack_len", acks, exp_len);
    reack = 1'b0;
    repeat (extra) begin
      @(posedge clk_sys); #1;
      if (sd_ack) reack = 1'b1;
    end
    chk("no_reserve", reack, 1'b0);
    sd_rd = 1'b0;
    sd_wr = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    chk("mem_rd_cnt", rd_acks - rd0, (is_rd && v) ? 256 : 0);
    chk("mem_we_cnt", we_acks - we0, (!is_rd && mem_used) ? 256 : 0);
    chk("bytes_left", exp_bytes.size(), 0);
    chk("words_left", exp_mw.size(), 0);
  endtask

  initial begin
    bit found;
    bit r, wsel;
    reset = 1'b1;
    img_mounted = 1'b0;
    img_size = 32'd0;
    sd_lba = 32'd0;
    sd_rd = 1'b0;
    sd_wr = 1'b0;
`ifdef SD_SERVER_WP_EN
    img_wp = 1'b0;
`endif
    for (int i = 0; i < 512; i++) ram[i] = 8'(i);
    ref_mem[byte_addr(3, 0) >> 1]  = 16'hA55A;
    phys_mem[byte_addr(3, 0) >> 1] = 16'hA55A;

    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_ack", sd_ack, 1'b0);
    chk("rst_bwr", sd_buff_wr, 1'b0);
    chk("rst_baddr", sd_buff_addr, 9'h0);
    chk("rst_bdout", sd_buff_dout, 8'h0);
    chk("rst_mem_rd", mem_rd, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 25'h0);
    chk("rst_mem_dout", mem_dout, 16'h0);
    reset = 1'b0;
    @(posedge clk_sys); #1;

    do_req(1, 0, 32'd3, 1, 32'd2048, 0, 3);
    do_req(1, 0, 32'd4, 1, 32'd2048, 0, 2);
    do_req(0, 1, 32'd1, 1, 32'd2048, 0, 1);
    do_req(1, 0, 32'd1, 1, 32'd2048, 0, 1);
    do_req(0, 1, 32'd2, 0, 32'd2048, 0, 1);
    do_req(1, 1, 32'd2, 1, 32'd2048, 0, 5);
    do_req(1, 0, 32'h0001_0003, 1, 32'hFFFF_FE00, 0, 1);

    for (int k = 0; k < 6; k++) begin
      for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
      r = 1'($urandom_range(0, 1));
      wsel = r ? 1'($urandom_range(0, 1)) : 1'b1;
      do_req(r, wsel, 32'($urandom_range(0, 7)),
             $urandom_range(0, 3) != 0, 32'd2048, 0,
             $urandom_range(1, 4));
    end

    // Reset while word 100 of a read is being fetched.
    for (int i = 0; i < 512; i++) begin
      logic [24:0] a;
      logic [15:0] d;
      a = byte_addr(1, i);
      d = ref_rd(a[24:1]);
      exp_bytes.push_back({9'(i), a[0] ? d[15:8] : d[7:0]});
    end
    img_mounted = 1'b1;
    img_size = 32'd2048;
    sd_lba = 32'd1;
    sd_rd = 1'b1;
    found = 1'b0;
    for (int c = 0; c < 4000 && !found; c++) begin
      @(posedge clk_sys); #1;
      if (mem_rd && mem_addr == byte_addr(1, 200)) found = 1'b1;
    end
    chk("rst_reach_w100", found, 1'b1);
    chk("rst_bytes_seen", exp_bytes.size(), 312);
    reset = 1'b1;
    exp_bytes.delete();
    @(posedge clk_sys); #1;
    chk("mid_rst_ack", sd_ack, 1'b0);
    chk("mid_rst_mem_rd", mem_rd, 1'b0);
    chk("mid_rst_bwr", sd_buff_wr, 1'b0);
    reset = 1'b0;
    sd_rd = 1'b0;
    repeat (2) @(posedge clk_sys);
    #1;
    do_req(1, 0, 32'd2, 1, 32'd2048, 0, 1);

`ifdef SD_SERVER_WP_EN
    for (int i = 0; i < 512; i++) ram[i] = 8'($urandom);
    do_req(0, 1, 32'd0, 1, 32'd2048, 1, 1);
    do_req(1, 0, 32'd0, 1, 32'd2048, 0, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
